// File: rtl/branch_history_table.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with the F-stage
// prediction carried down the pipeline to E, plus branch/mispredict statistics.
module branch_history_table #(
    parameter int ENTRY_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    input  logic [31:0] PCE,
    input  logic        IsBranchE,
    input  logic        BranchE,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    output logic        isBhtTakenF,
    output logic        isBhtTakenE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int DEPTH = 1 << ENTRY_BITS;

    logic [1:0]            ctr_q [DEPTH];
    logic [ENTRY_BITS-1:0] idx_f;
    logic [ENTRY_BITS-1:0] idx_e;
    logic [1:0]            ctr_e;
    logic [1:0]            ctr_d;
    logic                  update_en;
    logic                  pred_d_q, pred_d_d;
    logic                  pred_e_q, pred_e_d;
    logic [31:0]           branch_cnt_q, branch_cnt_d;
    logic [31:0]           mispred_cnt_q, mispred_cnt_d;

    assign idx_f       = PCF[ENTRY_BITS+1:2];
    assign idx_e       = PCE[ENTRY_BITS+1:2];
    assign isBhtTakenF = ctr_q[idx_f][1];
    assign isBhtTakenE = pred_e_q & IsBranchE;
    assign update_en   = IsBranchE & ~StallE & ~FlushE;
    assign ctr_e       = ctr_q[idx_e];

    always_comb begin
        ctr_d = ctr_e;
        if (BranchE) begin
            if (ctr_e != 2'b11) ctr_d = ctr_e + 2'b01;
        end else begin
            if (ctr_e != 2'b00) ctr_d = ctr_e - 2'b01;
        end
    end

    // Flush takes priority over stall in both stage registers.
    always_comb begin
        pred_d_d = isBhtTakenF;
        if (FlushD)      pred_d_d = 1'b0;
        else if (StallD) pred_d_d = pred_d_q;

        pred_e_d = pred_d_q;
        if (FlushE)      pred_e_d = 1'b0;
        else if (StallE) pred_e_d = pred_e_q;
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_en) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
            if (BranchE != isBhtTakenE) mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
        end else if (update_en) begin
            ctr_q[idx_e] <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_d_q      <= 1'b0;
            pred_e_q      <= 1'b0;
            branch_cnt_q  <= 32'd0;
            mispred_cnt_q <= 32'd0;
        end else begin
            pred_d_q      <= pred_d_d;
            pred_e_q      <= pred_e_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: driver pushes expected outputs from a
// table/pipeline reference model, a negedge monitor pops and compares.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PCF = 32'h0, PCE = 32'h0;
    logic        IsBranchE = 1'b0, BranchE = 1'b0;
    logic        StallD = 1'b0, FlushD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
    logic        isBhtTakenF, isBhtTakenE;
    logic [31:0] BranchCount, MispredCount;

    branch_history_table #(.ENTRY_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .PCE(PCE),
        .IsBranchE(IsBranchE), .BranchE(BranchE),
        .StallD(StallD), .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE),
        .isBhtTakenF(isBhtTakenF), .isBhtTakenE(isBhtTakenE),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pf;
        bit          pe;
        int          ent;
        int          idx;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   drv_done = 0;

    // Reference model: counter values as plain integers 0..3, pipeline as two bits.
    int          m_tbl [64];
    bit          m_d, m_e;
    int unsigned m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    task automatic model_reset();
        foreach (m_tbl[i]) m_tbl[i] = 1;
        m_d = 0; m_e = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic cycle(input bit rst, input logic [31:0] pcf, input logic [31:0] pce,
                         input bit isbr, input bit br, input bit sd, input bit fd,
                         input bit se, input bit fe);
        exp_t e;
        bit   nd, ne;
        @(posedge clk);
        #1;
        rst_n = !rst; PCF = pcf; PCE = pce; IsBranchE = isbr; BranchE = br;
        StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
        if (rst) model_reset();
        e.idx = idx_of(pcf);
        e.ent = m_tbl[e.idx];
        e.pf  = (m_tbl[e.idx] >= 2);
        e.pe  = m_e && isbr;
        e.bc  = m_bc;
        e.mc  = m_mc;
        sb.push_back(e);
        if (!rst) begin
            if (isbr && !se && !fe) begin
                m_bc++;
                if (br != e.pe) m_mc++;
                if (br) m_tbl[idx_of(pce)] = (m_tbl[idx_of(pce)] == 3) ? 3 : m_tbl[idx_of(pce)] + 1;
                else    m_tbl[idx_of(pce)] = (m_tbl[idx_of(pce)] == 0) ? 0 : m_tbl[idx_of(pce)] - 1;
            end
            nd = fd ? 1'b0 : (sd ? m_d : e.pf);
            ne = fe ? 1'b0 : (se ? m_e : m_d);
            m_d = nd;
            m_e = ne;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("isBhtTakenF", {31'd0, isBhtTakenF}, {31'd0, e.pf});
                chk("isBhtTakenE", {31'd0, isBhtTakenE}, {31'd0, e.pe});
                chk("entry", {30'd0, dut.ctr_q[e.idx]}, e.ent);
                chk("BranchCount", BranchCount, e.bc);
                chk("MispredCount", MispredCount, e.mc);
            end
        end
    end

    initial begin : driver
        logic [31:0] pcf, pce;
        model_reset();
        cycle(1, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        // Taken training, then read through an alias
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        cycle(0, 32'h110, 32'h0, 0, 0, 0, 0, 0, 0);
        // Four not-taken updates walk down to saturation
        for (int i = 0; i < 4; i++) cycle(0, 32'h10, 32'h10, 1, 0, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        // Held stall, then release
        for (int i = 0; i < 5; i++) cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 1, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        // Capture a taken prediction in D, then flush with stall
        cycle(0, 32'h10, 32'h40, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h40, 1, 1, 1, 1, 0, 0);
        cycle(0, 32'h10, 32'h40, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h40, 1, 1, 0, 0, 0, 0);
        // Same-cycle read and update of entry 4 from a fresh reset
        cycle(1, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        // Reset mid-stream with an update pending
        cycle(1, 32'h10, 32'h10, 1, 1, 0, 0, 0, 0);
        cycle(0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic over a small PC window to force hits and aliases
        for (int i = 0; i < 3000; i++) begin
            pcf = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 6'd0} | (32'($urandom_range(0, 3)) << 2);
            pce = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 6'd0} | (32'($urandom_range(0, 3)) << 2);
            cycle($urandom_range(0, 299) == 0, pcf, pce,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end
        drv_done = 1;
    end

    initial begin : finisher
        int guard;
        wait (drv_done);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
